// File: rtl/voter_fault_tracker_if.sv
// Voter-side bundle for the fault tracker: sample flags in, mode/exclusion/event
// counters out. The tracker takes the slave view; whoever drives the voter flags takes the master view.
interface voter_fault_tracker_if #(
  parameter int EVT_W = 16
);
  logic             valid_i;
  logic             err_detected_1_i;
  logic             err_detected_2_i;
  logic             err_detected_3_i;
  logic             err_corrected_i;
  logic             clr_i;
  logic             only_two_o;
  logic [1:0]       excl_o;
  logic [1:0]       state_o;
  logic             fatal_o;
  logic [EVT_W-1:0] err_evt_o;
  logic [EVT_W-1:0] corr_evt_o;

  modport slave (
    input  valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i,
           err_corrected_i, clr_i,
    output only_two_o, excl_o, state_o, fatal_o, err_evt_o, corr_evt_o
  );

  modport master (
    output valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i,
           err_corrected_i, clr_i,
    input  only_two_o, excl_o, state_o, fatal_o, err_evt_o, corr_evt_o
  );
endinterface

// File: rtl/voter_fault_tracker.sv
// Tracks consecutive per-replica voter errors and degrades TMR -> DMR -> failed,
// telling the voter which replica to drop. Also keeps saturating error/correction event counts.
module voter_fault_tracker #(
  parameter int THRESHOLD = 4,
  parameter int CNT_W     = 3,
  parameter int EVT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  voter_fault_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    TRIPLE = 2'b00,
    DUAL   = 2'b01,
    FAIL   = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  state_e           state_q, state_d;
  logic [1:0]       excl_q, excl_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       err;
  logic [2:0]       hits;
  logic             only_two_q, fatal_q;
  logic [EVT_W-1:0] err_evt_q, corr_evt_q;
  logic             sample;

  assign err    = {bus.err_detected_3_i, bus.err_detected_2_i, bus.err_detected_1_i};
  // A clear discards any sample arriving with it, event counters included.
  assign sample = bus.valid_i && !bus.clr_i;

  // Saturating run-length step: count up while the error persists, restart on a clean sample.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic hit);
    if (!hit)     return '0;
    if (c == THR) return THR;
    return c + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    excl_d  = excl_q;
    cnt_d   = cnt_q;
    hits    = '0;

    if (bus.clr_i) begin
      state_d = TRIPLE;
      excl_d  = 2'd0;
      cnt_d   = '{default: '0};
    end else if (bus.valid_i) begin
      unique case (state_q)
        TRIPLE: begin
          for (int k = 0; k < 3; k++) begin
            cnt_d[k] = bump(cnt_q[k], err[k]);
            hits[k]  = (cnt_d[k] == THR);
          end
          if (hits != 3'b000) begin
            cnt_d = '{default: '0};
            unique case (hits)
              3'b001:  begin state_d = DUAL; excl_d = 2'd1; end
              3'b010:  begin state_d = DUAL; excl_d = 2'd2; end
              3'b100:  begin state_d = DUAL; excl_d = 2'd3; end
              default: begin state_d = FAIL; excl_d = 2'd0; end
            endcase
          end
        end
        DUAL: begin
          // Survivors sit on voter inputs 1 and 2; input 3 carries nothing useful here.
          cnt_d[0] = bump(cnt_q[0], err[0] | err[1]);
          cnt_d[1] = '0;
          cnt_d[2] = '0;
          if (cnt_d[0] == THR) state_d = FAIL;
        end
        FAIL:    ;
        default: state_d = TRIPLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst) begin
      state_q    <= TRIPLE;
      excl_q     <= 2'd0;
      cnt_q      <= '{default: '0};
      only_two_q <= 1'b0;
      fatal_q    <= 1'b0;
      err_evt_q  <= '0;
      corr_evt_q <= '0;
    end else begin
      state_q    <= state_d;
      excl_q     <= excl_d;
      cnt_q      <= cnt_d;
      only_two_q <= (state_d != TRIPLE);
      fatal_q    <= (state_d == FAIL);
      if (sample && (err != 3'b000) && (err_evt_q != '1))
        err_evt_q <= err_evt_q + 1'b1;
      if (sample && bus.err_corrected_i && (corr_evt_q != '1))
        corr_evt_q <= corr_evt_q + 1'b1;
    end
  end

  assign bus.state_o    = state_q;
  assign bus.excl_o     = excl_q;
  assign bus.only_two_o = only_two_q;
  assign bus.fatal_o    = fatal_q;
  assign bus.err_evt_o  = err_evt_q;
  assign bus.corr_evt_o = corr_evt_q;

  a_state_legal: assert property (@(posedge clk) disable iff (rst) state_q != 2'b11);
  a_excl_mode:   assert property (@(posedge clk) disable iff (rst)
                                  (excl_q != 2'd0) |-> (state_q inside {DUAL, FAIL}));

endmodule

// File: tb/tb_voter_fault_tracker.sv
// Directed bench: one tracker with 16-bit event counters for the mode sequence,
// one with 4-bit event counters for saturation and idle-cycle behaviour.
module tb_voter_fault_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  voter_fault_tracker_if #(.EVT_W(16)) ia ();
  voter_fault_tracker_if #(.EVT_W(4))  ib ();

  voter_fault_tracker #(.THRESHOLD(4), .CNT_W(3), .EVT_W(16)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  voter_fault_tracker #(.THRESHOLD(4), .CNT_W(3), .EVT_W(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_a(input logic v, input logic e1, input logic e2, input logic e3,
                         input logic c, input logic cl);
    ia.valid_i = v; ia.err_detected_1_i = e1; ia.err_detected_2_i = e2;
    ia.err_detected_3_i = e3; ia.err_corrected_i = c; ia.clr_i = cl;
  endtask

  task automatic drive_b(input logic v, input logic e1, input logic e2, input logic e3,
                         input logic c, input logic cl);
    ib.valid_i = v; ib.err_detected_1_i = e1; ib.err_detected_2_i = e2;
    ib.err_detected_3_i = e3; ib.err_corrected_i = c; ib.clr_i = cl;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    drive_a(0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;

    // Reset state
    check("rst_state",    ia.state_o,    2'b00);
    check("rst_excl",     ia.excl_o,     2'd0);
    check("rst_only_two", ia.only_two_o, 1'b0);
    check("rst_fatal",    ia.fatal_o,    1'b0);
    check("rst_err_evt",  ia.err_evt_o,  16'd0);
    check("rst_corr_evt", ia.corr_evt_o, 16'd0);

    // Replica 3 keeps failing: exclusion after the 4th sample
    drive_a(1, 0, 0, 1, 1, 0);
    tick(3);
    check("r3_after3_state", ia.state_o, 2'b00);
    tick(1);
    check("r3_state",    ia.state_o,    2'b01);
    check("r3_excl",     ia.excl_o,     2'd3);
    check("r3_only_two", ia.only_two_o, 1'b1);
    check("r3_fatal",    ia.fatal_o,    1'b0);
    check("r3_err_evt",  ia.err_evt_o,  16'd4);
    check("r3_corr_evt", ia.corr_evt_o, 16'd4);

    // Surviving pair disagrees 4 times: FAIL with exclusion held
    drive_a(1, 1, 1, 0, 0, 0);
    tick(3);
    check("pair_after3_state", ia.state_o, 2'b01);
    tick(1);
    check("pair_state",   ia.state_o,   2'b10);
    check("pair_excl",    ia.excl_o,    2'd3);
    check("pair_fatal",   ia.fatal_o,   1'b1);
    check("pair_err_evt", ia.err_evt_o, 16'd8);

    // FAIL is sticky across a clean sample
    drive_a(1, 0, 0, 0, 0, 0);
    tick(1);
    check("fail_sticky", ia.state_o, 2'b10);

    // Clear with a simultaneous erroneous sample: sample discarded
    drive_a(1, 1, 0, 0, 1, 1);
    tick(1);
    drive_a(0, 0, 0, 0, 0, 0);
    check("clr_state",    ia.state_o,    2'b00);
    check("clr_excl",     ia.excl_o,     2'd0);
    check("clr_only_two", ia.only_two_o, 1'b0);
    check("clr_fatal",    ia.fatal_o,    1'b0);
    check("clr_err_evt",  ia.err_evt_o,  16'd8);
    check("clr_corr_evt", ia.corr_evt_o, 16'd4);

    // Interrupted run of replica-2 errors never reaches threshold
    drive_a(1, 0, 1, 0, 0, 0);
    tick(3);
    drive_a(1, 0, 0, 0, 0, 0);
    tick(1);
    drive_a(1, 0, 1, 0, 0, 0);
    tick(3);
    check("r2_broken_state", ia.state_o,   2'b00);
    check("r2_broken_evt",   ia.err_evt_o, 16'd14);
    drive_a(1, 0, 0, 0, 0, 0);
    tick(1);

    // All three replicas fail together: FAIL with no exclusion
    drive_a(1, 1, 1, 1, 0, 0);
    tick(4);
    check("all_state",    ia.state_o,    2'b10);
    check("all_fatal",    ia.fatal_o,    1'b1);
    check("all_excl",     ia.excl_o,     2'd0);
    check("all_only_two", ia.only_two_o, 1'b1);
    check("all_err_evt",  ia.err_evt_o,  16'd18);

    // Reset coinciding with the threshold-reaching sample wins
    drive_a(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    drive_a(1, 1, 0, 0, 1, 0);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rstwin_state",    ia.state_o,    2'b00);
    check("rstwin_excl",     ia.excl_o,     2'd0);
    check("rstwin_only_two", ia.only_two_o, 1'b0);
    check("rstwin_fatal",    ia.fatal_o,    1'b0);
    check("rstwin_err_evt",  ia.err_evt_o,  16'd0);
    check("rstwin_corr_evt", ia.corr_evt_o, 16'd0);
    tick(1);
    check("rstwin_cnt_cleared", ia.state_o,   2'b00);
    check("rstwin_evt_restart", ia.err_evt_o, 16'd1);
    drive_a(0, 0, 0, 0, 0, 0);

    // Narrow event counters: idle cycles with flags high change nothing
    drive_b(1, 1, 0, 0, 1, 0);
    tick(2);
    drive_b(0, 1, 1, 1, 1, 0);
    tick(3);
    check("idle_err_evt",  ib.err_evt_o,  4'd2);
    check("idle_corr_evt", ib.corr_evt_o, 4'd2);
    check("idle_state",    ib.state_o,    2'b00);
    drive_b(1, 1, 0, 0, 1, 0);
    tick(1);
    check("idle_cnt_held", ib.state_o, 2'b00);
    tick(1);
    check("b_dual_state", ib.state_o, 2'b01);
    check("b_dual_excl",  ib.excl_o,  2'd1);
    tick(11);
    check("b_evt_at_max",  ib.err_evt_o, 4'd15);
    check("b_fail_state",  ib.state_o,   2'b10);
    tick(5);
    check("b_err_evt_sat",  ib.err_evt_o,  4'd15);
    check("b_corr_evt_sat", ib.corr_evt_o, 4'd15);
    check("b_fail_excl",    ib.excl_o,     2'd1);
    drive_b(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/voter_fault_tracker.md
VOTER_FAULT_TRACKER -- requirements
Module: voter_fault_tracker

Interface
REQ-001 The block SHALL have parameter THRESHOLD, default 4, consecutive erroneous votes that mark a replica (or the surviving pair) faulty; legal range 1..2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 3, width of each consecutive-error counter.
REQ-003 The block SHALL have parameter EVT_W, default 16, width of the saturating event counters.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 valid_i  input  1  the voter flags below are a meaningful sample this cycle.
REQ-007 err_detected_1_i / _2_i / _3_i  input  1 each  per-replica error flags from the 3-way majority voter.
REQ-008 err_corrected_i  input  1  voter masked the error this cycle.
REQ-009 clr_i  input  1  clears fault state and counters; event counters are kept.
REQ-010 only_two_o  output  1  drives the voter's only_two input; 1 in DUAL and FAIL.
REQ-011 excl_o  output  2  excluded replica: 0 none, 1/2/3 replica index; the input remap places the two survivors in ascending order on voter inputs 1 and 2.
REQ-012 state_o  output  2  00 TRIPLE, 01 DUAL, 10 FAIL.
REQ-013 fatal_o  output  1  1 while in FAIL.
REQ-014 err_evt_o  output  EVT_W  count of valid samples with any error flag set.
REQ-015 corr_evt_o  output  EVT_W  count of valid samples with err_corrected_i set.

Function
REQ-016 The block SHALL implement the FSM TRIPLE, DUAL and FAIL; all outputs SHALL be registered, so a state change caused by the sample in cycle N SHALL be visible in cycle N+1.
REQ-017 Priority SHALL be rst, then clr_i, then a valid_i sample; cycles with valid_i=0 SHALL leave all counters and state unchanged.
REQ-018 In TRIPLE with a valid sample: cnt_k SHALL increment, saturating at THRESHOLD, when err_detected_k_i=1, and SHALL clear to 0 when err_detected_k_i=0 (k=1..3).
REQ-019 In TRIPLE: if exactly one cnt_k reaches THRESHOLD on a given sample, the next state SHALL be DUAL with excl_o=k and all cnt cleared.
REQ-020 In TRIPLE: if two or more counters reach THRESHOLD on the same sample, the next state SHALL be FAIL with excl_o=0.
REQ-021 In DUAL: err_detected_3_i SHALL be ignored; a pair-mismatch counter (cnt_1 reused) SHALL increment on valid samples with err_detected_1_i|err_detected_2_i and SHALL clear otherwise.
REQ-022 In DUAL: when the pair-mismatch counter reaches THRESHOLD, the next state SHALL be FAIL and excl_o SHALL be held.
REQ-023 FAIL SHALL be sticky; only rst or clr_i SHALL leave it.
REQ-024 clr_i from any state SHALL return to TRIPLE with excl_o=0 and all cnt=0 in the next cycle; a valid sample in the same cycle SHALL be discarded.
REQ-025 err_evt_o and corr_evt_o SHALL increment by 1 per qualifying valid sample in every state, including FAIL, and SHALL saturate at 2^EVT_W-1 without wrap.
REQ-026 THRESHOLD=1 SHALL cause a transition on the first erroneous sample.
REQ-027 Simulation assertions SHALL check that state_o is never 11 and that excl_o is nonzero only in DUAL or FAIL.

Reset
REQ-028 On rst=1 at a clock edge, the following SHALL hold next cycle: state_o=00, excl_o=0, only_two_o=0, fatal_o=0, all cnt=0, err_evt_o=0, corr_evt_o=0.
REQ-029 rst asserted mid-transition, for example on the same edge where a counter would reach THRESHOLD, SHALL win, and the FSM SHALL stay in TRIPLE.

Verification (THRESHOLD=4)
REQ-030 4 consecutive valid samples with err_3=1 -> cycle after the 4th: state_o=01, excl_o=3, only_two_o=1; err_evt_o=4, corr_evt_o=4.
REQ-031 err_2=1 on 3 valid samples, then 1 clean sample, then 3 more with err_2=1 -> state_o remains 00.
REQ-032 4 valid samples with err_1=err_2=err_3=1 -> state_o=10, fatal_o=1, excl_o=0.
REQ-033 In DUAL with excl_o=3: 4 valid samples with err_1=err_2=1 -> state_o=10, excl_o=3; then clr_i=1 -> state_o=00, excl_o=0, event counters unchanged.
REQ-034 EVT_W=4: 20 erroneous samples -> err_evt_o=15; valid_i=0 with flags high -> no change in any counter or state.
REQ-035 rst=1 together with the 4th err_1 sample -> next cycle state_o=00 and all outputs at reset values.
